// File: rtl/cxl_speckv_pkg.sv
// Shared CXL.mem definitions: cache-line geometry and the request record
// used by the responder and the future requester-side buffers.
package cxl_speckv_pkg;

  localparam int CL_BYTES   = 64;
  localparam int CL_SHIFT   = 6;
  localparam int CXL_DATA_W = 512;

  typedef struct packed {
    logic                  write;
    logic [63:0]           addr;
    logic [CXL_DATA_W-1:0] data;
  } cxl_mem_req_t;

endpackage

// File: rtl/cxl_mem_resp_fifo.sv
// Synchronous FIFO with a registered storage array. The read port shows the
// head entry, or zero when empty.
module cxl_mem_resp_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == (PW+1)'(DEPTH));
  assign do_pop   = pop & ~empty;
  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    cnt_d    = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/cxl_mem_responder.sv
// CXL.mem responder: window-checks line requests, issues them to a fixed-latency
// memory port and returns one in-order response per request through a credited FIFO.
module cxl_mem_responder
  import cxl_speckv_pkg::*;
#(
  parameter int          ADDR_WIDTH = 64,
  parameter int          DATA_WIDTH = 512,
  parameter int          MEM_AW     = 20,
  parameter logic [63:0] BASE_ADDR  = 64'h0,
  parameter int          MEM_LAT    = 2,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cxl_mem_req_valid,
  output logic                          cxl_mem_req_ready,
  input  logic                          cxl_mem_req_write,
  input  logic [ADDR_WIDTH-1:0]         cxl_mem_req_addr,
  input  logic [DATA_WIDTH-1:0]         cxl_mem_req_data,
  output logic                          cxl_mem_resp_valid,
  input  logic                          cxl_mem_resp_ready,
  output logic [DATA_WIDTH-1:0]         cxl_mem_resp_data,
  output logic                          mem_rd_en,
  output logic                          mem_wr_en,
  output logic [MEM_AW-1:0]             mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   outstanding,
  output logic [31:0]                   err_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  cxl_mem_req_t          req;
  logic [ADDR_WIDTH-1:0] req_addr, line_off;
  logic                  in_range, accept, pop, push;
  logic                  fifo_empty, fifo_full;
  logic [DATA_WIDTH-1:0] push_data;

  logic                  mem_rd_en_q, mem_rd_en_d;
  logic                  mem_wr_en_q, mem_wr_en_d;
  logic [MEM_AW-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [MEM_LAT:0]      pipe_vld_q, pipe_vld_d;
  logic [MEM_LAT:0]      pipe_rd_q, pipe_rd_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [31:0]           err_count_q, err_count_d;

  always_comb begin
    req       = '0;
    req.write = cxl_mem_req_write;
    req.addr  = 64'(cxl_mem_req_addr);
    req.data  = CXL_DATA_W'(cxl_mem_req_data);
  end

  // Line offset from the window base; any bit above MEM_AW means out of window.
  assign req_addr = req.addr[ADDR_WIDTH-1:0];
  assign line_off = (req_addr - BASE) >> CL_SHIFT;
  assign in_range = (req_addr >= BASE) && (line_off[ADDR_WIDTH-1:MEM_AW] == '0);

  assign cxl_mem_req_ready  = (outstanding_q < CW'(FIFO_DEPTH));
  assign accept             = cxl_mem_req_valid & cxl_mem_req_ready;
  assign cxl_mem_resp_valid = ~fifo_empty;
  assign pop                = cxl_mem_resp_valid & cxl_mem_resp_ready;

  always_comb begin
    mem_rd_en_d   = accept & in_range & ~req.write;
    mem_wr_en_d   = accept & in_range & req.write;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    err_count_d   = err_count_q;
    outstanding_d = outstanding_q;
    if (accept) begin
      mem_addr_d  = line_off[MEM_AW-1:0];
      mem_wdata_d = DATA_WIDTH'(req.data);
    end
    if (accept && !in_range && (err_count_q != 32'hFFFF_FFFF))
      err_count_d = err_count_q + 32'd1;
    // Stage 0 lines up with the issue registers; stage MEM_LAT with mem_rdata.
    pipe_vld_d = {pipe_vld_q[MEM_LAT-1:0], accept};
    pipe_rd_d  = {pipe_rd_q[MEM_LAT-1:0], mem_rd_en_d};
    case ({accept, pop})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd_en_q   <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      pipe_vld_q    <= '0;
      pipe_rd_q     <= '0;
      outstanding_q <= '0;
      err_count_q   <= '0;
    end else begin
      mem_rd_en_q   <= mem_rd_en_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      pipe_vld_q    <= pipe_vld_d;
      pipe_rd_q     <= pipe_rd_d;
      outstanding_q <= outstanding_d;
      err_count_q   <= err_count_d;
    end
  end

  assign push      = pipe_vld_q[MEM_LAT];
  assign push_data = pipe_rd_q[MEM_LAT] ? mem_rdata : '0;

  cxl_mem_resp_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (cxl_mem_resp_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Credits cover every in-flight and queued response, so the FIFO never overflows.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));

  assign mem_rd_en   = mem_rd_en_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign outstanding = outstanding_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_cxl_mem_responder.sv
// Directed bench for cxl_mem_responder: single-request vector table plus
// backpressure, streaming, credit, and reset sequences against a memory model.
module tb_cxl_mem_responder;

  localparam int AW    = 64;
  localparam int DW    = 512;
  localparam int MAW   = 20;
  localparam int DEPTH = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic           req_write = 1'b0;
  logic [AW-1:0]  req_addr = '0;
  logic [DW-1:0]  req_data = '0;
  logic           resp_valid;
  logic           resp_ready = 1'b0;
  logic [DW-1:0]  resp_data;
  logic           mem_rd_en, mem_wr_en;
  logic [MAW-1:0] mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic [DW-1:0]  mem_rdata = '0;
  logic [3:0]     outstanding;
  logic [31:0]    err_count;

  cxl_mem_responder #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MEM_AW     (MAW),
    .BASE_ADDR  (64'h0),
    .MEM_LAT    (2),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cxl_mem_req_valid  (req_valid),
    .cxl_mem_req_ready  (req_ready),
    .cxl_mem_req_write  (req_write),
    .cxl_mem_req_addr   (req_addr),
    .cxl_mem_req_data   (req_data),
    .cxl_mem_resp_valid (resp_valid),
    .cxl_mem_resp_ready (resp_ready),
    .cxl_mem_resp_data  (resp_data),
    .mem_rd_en          (mem_rd_en),
    .mem_wr_en          (mem_wr_en),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_rdata          (mem_rdata),
    .outstanding        (outstanding),
    .err_count          (err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] linePat(input logic [MAW-1:0] idx);
    linePat = {16{12'hC0D, idx}};
  endfunction

  // Backing memory: two-cycle read latency, writes visible to the next read.
  logic [DW-1:0] mem_model [logic [MAW-1:0]];
  logic [DW-1:0] rd_stage = '0;

  always @(posedge clk) begin
    if (mem_rd_en)
      rd_stage <= mem_model.exists(mem_addr) ? mem_model[mem_addr] : linePat(mem_addr);
    else
      rd_stage <= '0;
    mem_rdata <= rd_stage;
    if (mem_wr_en) mem_model[mem_addr] = mem_wdata;
  end

  int n_checks = 0;
  int n_fails  = 0;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic           wr;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    logic           exp_rd;
    logic           exp_wr;
    logic [MAW-1:0] exp_maddr;
    logic [DW-1:0]  exp_resp;
  } vec_t;

  vec_t vecs [8];

  task automatic applyStimulus(input vec_t v);
    int lat;
    req_valid = 1'b1;
    req_write = v.wr;
    req_addr  = v.addr;
    req_data  = v.wdata;
    checkOutput("vec_req_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_data  = '0;
    checkOutput("vec_mem_rd_en", mem_rd_en, v.exp_rd);
    checkOutput("vec_mem_wr_en", mem_wr_en, v.exp_wr);
    if (v.exp_rd || v.exp_wr) checkOutput("vec_mem_addr", mem_addr, v.exp_maddr);
    if (v.exp_wr) checkOutput("vec_mem_wdata", mem_wdata, v.wdata);
    lat = 1;
    while (!resp_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("vec_latency", lat, 4);
    checkOutput("vec_strobe_single", mem_rd_en | mem_wr_en, 0);
    checkOutput("vec_resp_data", resp_data, v.exp_resp);
    @(posedge clk); #1;
    checkOutput("vec_resp_cleared", resp_valid, 0);
  endtask

  initial begin
    logic [DW-1:0] pat_a5, pat_x;
    int acc, got, first, last, cnt;

    pat_a5 = {64{8'hA5}};
    pat_x  = {8{64'h0123_4567_89AB_CDEF}};
    vecs[0] = '{1'b1, 64'h1000,                 pat_a5, 1'b0, 1'b1, 20'h40,    512'h0};
    vecs[1] = '{1'b0, 64'h1000,                 512'h0, 1'b1, 1'b0, 20'h40,    pat_a5};
    vecs[2] = '{1'b0, 64'h2000,                 512'h0, 1'b1, 1'b0, 20'h80,    linePat(20'h80)};
    vecs[3] = '{1'b0, 64'h103F,                 512'h0, 1'b1, 1'b0, 20'h40,    pat_a5};
    vecs[4] = '{1'b0, 64'h400_0000,             512'h0, 1'b0, 1'b0, 20'h0,     512'h0};
    vecs[5] = '{1'b1, 64'h3FF_FFC0,             pat_x,  1'b0, 1'b1, 20'hFFFFF, 512'h0};
    vecs[6] = '{1'b0, 64'h3FF_FFC0,             512'h0, 1'b1, 1'b0, 20'hFFFFF, pat_x};
    vecs[7] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFC0,  512'h0, 1'b0, 1'b0, 20'h0,     512'h0};

    #12;
    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_resp_valid", resp_valid, 0);
    checkOutput("rst_resp_data", resp_data, 0);
    checkOutput("rst_outstanding", outstanding, 0);
    checkOutput("rst_err_count", err_count, 0);
    checkOutput("rst_mem_strobes", {mem_rd_en, mem_wr_en}, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] vector table");
    resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);
    checkOutput("table_err_count", err_count, 2);
    checkOutput("table_outstanding", outstanding, 0);

    $display("[TB] backpressure");
    resp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1;
      req_addr  = 64'h10000 + 64'(acc) * 64;
      if (req_ready) acc++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    checkOutput("bp_accepted", acc, 8);
    checkOutput("bp_req_ready", req_ready, 0);
    checkOutput("bp_outstanding", outstanding, 8);
    resp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checkOutput("bp_drain_valid", resp_valid, 1);
      checkOutput("bp_drain_data", resp_data, linePat(20'h400 + 20'(k)));
      @(posedge clk); #1;
      if (k == 0) begin
        checkOutput("bp_ready_after_pop", req_ready, 1);
        checkOutput("bp_outstanding_after_pop", outstanding, 7);
      end
    end
    checkOutput("bp_drained_valid", resp_valid, 0);
    checkOutput("bp_drained_outstanding", outstanding, 0);

    $display("[TB] streaming");
    got = 0; first = -1; last = -1;
    for (int c = 0; c < 32; c++) begin
      if (c >= 5 && c <= 16) checkOutput("stream_outstanding", outstanding, 4);
      if (resp_valid) begin
        checkOutput("stream_data", resp_data, linePat(20'h800 + 20'(got)));
        if (first < 0) first = c;
        last = c;
        got++;
      end
      if (c < 16) begin
        req_valid = 1'b1;
        req_addr  = 64'h20000 + 64'(c) * 64;
        checkOutput("stream_req_ready", req_ready, 1);
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    checkOutput("stream_count", got, 16);
    checkOutput("stream_first_cycle", first, 4);
    checkOutput("stream_contiguous", last - first, 15);

    $display("[TB] simultaneous accept and pop");
    resp_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      req_valid = 1'b1;
      req_addr  = 64'h30000 + 64'(i) * 64;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    checkOutput("sim_pre_outstanding", outstanding, 7);
    checkOutput("sim_pre_ready", req_ready, 1);
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 64'h30000 + 64'd7 * 64;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    checkOutput("sim_outstanding", outstanding, 7);
    checkOutput("sim_ready", req_ready, 1);
    resp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 30; c++) begin
      if (resp_valid) begin
        checkOutput("sim_drain_data", resp_data, linePat(20'hC01 + 20'(got)));
        got++;
      end
      @(posedge clk); #1;
    end
    checkOutput("sim_drain_count", got, 7);
    checkOutput("sim_drain_outstanding", outstanding, 0);

    $display("[TB] reset mid-operation");
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_addr  = 64'h40000 + 64'(i) * 64;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("rmo_pre_valid", resp_valid, 1);
    checkOutput("rmo_pre_outstanding", outstanding, 3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rmo_resp_valid", resp_valid, 0);
    checkOutput("rmo_outstanding", outstanding, 0);
    checkOutput("rmo_req_ready", req_ready, 1);
    checkOutput("rmo_err_count", err_count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    resp_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (resp_valid) cnt++;
    end
    checkOutput("rmo_no_response", cnt, 0);
    checkOutput("rmo_post_outstanding", outstanding, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
